data_mem_responder: RTL and testbench

- Memory-side responder for the processor's data-register load/store path.
- Owns a synchronous single-port data RAM holding 10-bit pixel words.
- Services one mem_write or mem_read request at a time with a fixed, parameterised latency, then signals completion with a one-cycle done pulse.
- mem_rdata feeds the data register's memory-input path. The register's store output (low 10 bits) drives mem_wdata.

---
 rtl/mem_if_pkg.sv | 25 ++
 rtl/mem_ram_sp.sv | 29 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM states
// and the legal read-latency range.
package mem_if_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int ADDR_W_DEF = 16;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        WR_COMMIT = 3'd2,
        DONE      = 3'd3,
        REARM     = 3'd4
    } state_t;

    // Latency counter preload: the counter hits zero on the last RD_WAIT cycle.
    function automatic logic [CNT_W-1:0] lat_preload(input int rd_lat);
        return CNT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Synchronous single-port RAM, registered read returning the pre-write
// contents when read and write hit the same address in one cycle.
module mem_ram_sp
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
        rdata_reg <= mem_array[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-register load/store path: accepts one
// request at a time, completes it after a fixed latency and pulses done.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_write,
    input  logic              mem_read,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("data_mem_responder: RD_LAT out of range 1..7");
        end
        if (RAM_AW > ADDR_W) begin : g_bad_depth
            $error("data_mem_responder: DEPTH exceeds address space");
        end
    endgenerate

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic              addr_ok;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] ram_rdata;

    assign addr_ok = ({1'b0, addr_reg} < DEPTH_X);
    assign ram_we  = (state_reg == WR_COMMIT) && addr_ok;

    // In IDLE the RAM is addressed straight from the bus so the read launched
    // on the acceptance edge already has data by the first RD_WAIT cycle;
    // this is what lets RD_LAT=1 complete in time.
    assign ram_idx = (state_reg == IDLE) ? mem_addr[RAM_AW-1:0]
                                         : addr_reg[RAM_AW-1:0];

    mem_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_write) begin
                        addr_reg  <= mem_addr;
                        wdata_reg <= mem_wdata;
                        busy_reg  <= 1'b1;
                        state_reg <= WR_COMMIT;
                    end else if (mem_read) begin
                        addr_reg  <= mem_addr;
                        cnt_reg   <= lat_preload(RD_LAT);
                        busy_reg  <= 1'b1;
                        state_reg <= RD_WAIT;
                    end
                end
                WR_COMMIT: begin
                    if (!addr_ok) begin
                        err_reg <= 1'b1;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                RD_WAIT: begin
                    if (cnt_reg == '0) begin
                        if (addr_ok) begin
                            rdata_reg <= ram_rdata;
                        end else begin
                            rdata_reg <= '0;
                            err_reg   <= 1'b1;
                        end
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= REARM;
                end
                REARM: begin
                    // A request still held from the last transfer must drop first.
                    if (!mem_write && !mem_read) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign addr_err  = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (RD_LAT 2/1/7, DEPTH 1024)
// driven by directed and random transactions against a behavioural model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [15:0] a_s     [3];
    logic [9:0]  wd_s    [3];
    logic        wr_s    [3];
    logic        rd_s    [3];
    logic [9:0]  rdata_s [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        err_s   [3];

    int lat_tab [3] = '{2, 1, 7};

    data_mem_responder #(.DATA_W(10), .ADDR_W(16), .DEPTH(1024), .RD_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(a_s[0]), .mem_wdata(wd_s[0]),
        .mem_write(wr_s[0]), .mem_read(rd_s[0]), .mem_rdata(rdata_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .addr_err(err_s[0]));

    data_mem_responder #(.DATA_W(10), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(a_s[1]), .mem_wdata(wd_s[1]),
        .mem_write(wr_s[1]), .mem_read(rd_s[1]), .mem_rdata(rdata_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .addr_err(err_s[1]));

    data_mem_responder #(.DATA_W(10), .ADDR_W(16), .DEPTH(1024), .RD_LAT(7)) u_dut2 (
        .clk(clk), .rst(rst), .mem_addr(a_s[2]), .mem_wdata(wd_s[2]),
        .mem_write(wr_s[2]), .mem_read(rd_s[2]), .mem_rdata(rdata_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .addr_err(err_s[2]));

    // Behavioural model: word store, written flags, expected read register and error flag.
    logic [9:0] mdl  [3][1024];
    bit         wrn  [3][1024];
    logic [9:0] rexp [3];
    bit         eexp [3];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rexp[k] = '0;
            eexp[k] = 1'b0;
        end
    endtask

    // One request held for the whole transfer, plus `hold` extra cycles after done.
    task automatic xact(input int i, input bit wr, input bit rd, input logic [15:0] a,
                        input logic [9:0] wd, input int hold);
        bit in_rng;
        int lat;
        in_rng = (32'(a) < 1024);
        lat    = wr ? 2 : lat_tab[i] + 1;
        if (wr) begin
            if (in_rng) begin
                mdl[i][a[9:0]] = wd;
                wrn[i][a[9:0]] = 1'b1;
            end else begin
                eexp[i] = 1'b1;
            end
        end else if (rd) begin
            if (in_rng) begin
                rexp[i] = mdl[i][a[9:0]];
            end else begin
                rexp[i] = '0;
                eexp[i] = 1'b1;
            end
        end
        $display("[TB] inst%0d wr=%0d rd=%0d addr=%04h wdata=%03h hold=%0d exp_rdata=%03h exp_err=%0d",
                 i, wr, rd, a, wd, hold, rexp[i], eexp[i]);
        @(negedge clk);
        a_s[i]  = a;
        wd_s[i] = wd;
        wr_s[i] = wr;
        rd_s[i] = rd;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            chk("busy_inflight", i, 32'(busy_s[i]), 32'(1));
            chk("done_timing", i, 32'(done_s[i]), 32'(c == lat));
            if (c == 1) begin
                a_s[i]  = 16'($urandom);
                wd_s[i] = 10'($urandom);
            end
            if (c == lat) begin
                chk("rdata_at_done", i, 32'(rdata_s[i]), 32'(rexp[i]));
                chk("err_at_done", i, 32'(err_s[i]), 32'(eexp[i]));
                @(negedge clk);
                chk("rdata_negedge", i, 32'(rdata_s[i]), 32'(rexp[i]));
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("held_no_done", i, 32'(done_s[i]), 32'(0));
            chk("held_not_busy", i, 32'(busy_s[i]), 32'(0));
        end
        @(negedge clk);
        wr_s[i] = 1'b0;
        rd_s[i] = 1'b0;
        @(posedge clk);
        #1;
        chk("rearm_no_done", i, 32'(done_s[i]), 32'(0));
        @(posedge clk);
        #1;
        chk("idle_busy", i, 32'(busy_s[i]), 32'(0));
        chk("rdata_hold", i, 32'(rdata_s[i]), 32'(rexp[i]));
    endtask

    initial begin
        logic [15:0] pool [7];
        for (int k = 0; k < 3; k++) begin
            a_s[k] = '0; wd_s[k] = '0; wr_s[k] = 1'b0; rd_s[k] = 1'b0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdata", k, 32'(rdata_s[k]), 32'(0));
            chk("rst_busy", k, 32'(busy_s[k]), 32'(0));
            chk("rst_done", k, 32'(done_s[k]), 32'(0));
            chk("rst_err", k, 32'(err_s[k]), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // Round trip, simultaneous request, held request.
        xact(0, 1'b1, 1'b0, 16'h0012, 10'h2A5, 0);
        xact(0, 1'b0, 1'b1, 16'h0012, 10'h000, 0);
        xact(0, 1'b1, 1'b1, 16'h0040, 10'h155, 0);
        xact(0, 1'b0, 1'b1, 16'h0040, 10'h000, 0);
        xact(0, 1'b0, 1'b1, 16'h0012, 10'h000, 7);

        // Out of range: no aliasing onto word 0, sticky error.
        xact(0, 1'b1, 1'b0, 16'h0000, 10'h0AA, 0);
        xact(0, 1'b1, 1'b0, 16'h0400, 10'h3FF, 0);
        xact(0, 1'b0, 1'b1, 16'h0400, 10'h000, 0);
        xact(0, 1'b0, 1'b1, 16'h0000, 10'h000, 0);
        xact(0, 1'b0, 1'b1, 16'h0012, 10'h000, 0);

        // Reset in the middle of a read aborts it without a done pulse.
        $display("[TB] inst0 reset during RD_WAIT of addr=0040");
        @(negedge clk);
        a_s[0] = 16'h0040;
        rd_s[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy_before", 0, 32'(busy_s[0]), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("abort_busy", 0, 32'(busy_s[0]), 32'(0));
        chk("abort_done", 0, 32'(done_s[0]), 32'(0));
        chk("abort_rdata", 0, 32'(rdata_s[0]), 32'(0));
        chk("abort_err", 0, 32'(err_s[0]), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rd_s[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 0, 32'(done_s[0]), 32'(0));
        end
        xact(0, 1'b0, 1'b1, 16'h0012, 10'h000, 0);

        // Latency extremes.
        xact(1, 1'b1, 1'b0, 16'h0012, 10'h111, 0);
        xact(1, 1'b0, 1'b1, 16'h0012, 10'h000, 0);
        xact(2, 1'b1, 1'b0, 16'h03FF, 10'h222, 0);
        xact(2, 1'b0, 1'b1, 16'h03FF, 10'h000, 2);

        // Random traffic across all three instances.
        pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0012; pool[3] = 16'h03FF;
        pool[4] = 16'h0400; pool[5] = 16'hFFFF; pool[6] = 16'h0000;
        for (int n = 0; n < 40; n++) begin
            int          i;
            int          op;
            logic [15:0] a;
            bit          wr;
            bit          rd;
            i  = int'($urandom_range(0, 2));
            op = int'($urandom_range(0, 2));
            pool[6] = 16'($urandom_range(0, 1023));
            a  = pool[$urandom_range(0, 6)];
            wr = (op != 1);
            rd = (op != 0);
            if (!wr && 32'(a) < 1024 && !wrn[i][a[9:0]]) begin
                wr = 1'b1;
            end
            xact(i, wr, rd, a, 10'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
